// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle chunked adder/subtractor with start/busy/done handshake
//
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying
// between chunks through a register so no full-width carry chain exists.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request an operation (sampled only while idle)
//   sub    - 0: a+b, 1: a-b (captured with start)
//   a, b   - operands (captured with start)
//   busy   - operation in progress
//   done   - one-cycle pulse when q/c_out/ovf become valid
//   q      - result, held until the next completion
//   c_out  - carry out of the MSB (for subtract: 1 = no borrow)
//   ovf    - two's-complement signed overflow
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cr_q, cr_d;
  logic             done_q, done_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] s;
  logic             cy;
  logic             msb_cin;
  logic             last;
  logic [WIDTH-1:0] ra_next;

  // Chunk datapath: low CHUNK bits of the shift registers plus carry register.
  always_comb begin
    {cy, s} = {1'b0, sa_q[CHUNK-1:0]} + {1'b0, sb_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cr_q};
    // Carry into the top bit of this chunk, recovered from its sum bit; only
    // meaningful on the final chunk, where that bit is the operand MSB.
    msb_cin = s[CHUNK-1] ^ sa_q[CHUNK-1] ^ sb_q[CHUNK-1];
    last    = (cnt_q == CW'(N - 1));
    // New sum chunk enters at the top; after N chunks the first one has
    // reached bit 0.
    ra_next = (ra_q >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ra_d    = ra_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    cr_d    = cr_q;
    done_d  = 1'b0;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction as a + ~b + 1: invert b here, inject the +1 as carry-in.
          sa_d    = a;
          sb_d    = b ^ {WIDTH{sub}};
          cr_d    = sub;
          ra_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> CHUNK;
        sb_d  = sb_q >> CHUNK;
        ra_d  = ra_next;
        cr_d  = cy;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          q_d     = ra_next;
          c_out_d = cy;
          ovf_d   = msb_cin ^ cy;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ra_q    <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      cr_q    <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ra_q    <= ra_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      cr_q    <= cr_d;
      done_q  <= done_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign q     = q_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/chunked_add_sub.md
# chunked_add_sub

Parametrised multi-cycle adder/subtractor for the calculator datapath, the next generation of the 16-bit ripple adder. It processes `CHUNK` bits per clock with a registered carry between chunks, so wide operands can be added without one long combinational carry chain. It adds a subtract mode, signed-overflow detection and a start/busy/done handshake. The calculator control FSM and the shift-add multiplier use it as their shared add/sub engine.

## Interface
- `WIDTH`, default 16: operand and result width in bits; must be ≥ 2.
- `CHUNK`, default 4: bits processed per cycle; `WIDTH % CHUNK` must be 0. `N = WIDTH/CHUNK`.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request an operation; sampled only when `busy`=0.
- `sub` input 1: 0 = A+B, 1 = A−B; captured with `start`.
- `a` input WIDTH: operand A; captured with `start`.
- `b` input WIDTH: operand B; captured with `start`.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when the result becomes valid.
- `q` output WIDTH: result, registered, held until the next completion.
- `c_out` output 1: raw carry out of the MSB.
- `ovf` output 1: two's-complement signed overflow.

## Operation
- **States:**
  - IDLE: `busy`=0.
  - RUN: `busy`=1, chunk counter 0..N−1.
  - IDLE again after the last chunk. There is no separate DONE state; `done` is a registered pulse.
- **Capture:** on an edge where `busy`=0 and `start`=1:
  - latch `a` into shift register SA;
  - latch `b ^ {WIDTH{sub}}` into SB;
  - set carry register CR = `sub`;
  - set counter = 0 and enter RUN.
- **Each RUN edge:**
  - compute `{cy, s} = SA[CHUNK-1:0] + SB[CHUNK-1:0] + CR` (CHUNK+1 bits);
  - shift SA and SB right by CHUNK;
  - shift `s` into the top of the result accumulator RA;
  - set CR = `cy`;
  - increment the counter.
- **On the final chunk (counter = N−1):**
  - load `q` with the completed RA value;
  - set `c_out` = `cy`;
  - set `ovf` = (carry into the MSB) XOR (carry out of the MSB), computed inside the final chunk;
  - pulse `done` = 1 and return to IDLE.
- **Subtraction:** `c_out`=1 means no borrow, i.e. unsigned `a ≥ b`.
- **Stability:** `q`, `c_out` and `ovf` are updated only on the final edge. They hold their previous values throughout RUN.
- **Start during RUN:** `start` is ignored while `busy`=1. Operand changes during RUN have no effect.
- **Start in the `done` cycle:** `busy` is already 0, so the request is accepted. That edge clears `done` and sets `busy`.
- **Reset:** while `rst`=1, regardless of state (including mid-RUN):
  - `busy`, `done`, `q`, `c_out` and `ovf` are 0 immediately;
  - all internal registers are cleared;
  - state = IDLE.
  After release, the block is idle and the aborted operation produces no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `q`=0, `c_out`=0, `ovf`=0.
- Numbering the capture edge as edge 0:
  - `busy`=1 after edge 0;
  - chunks are computed on edges 1..N;
  - after edge N: `busy`=0, `done`=1, `q`/`c_out`/`ovf` valid;
  - `done` returns to 0 after edge N+1.
- Latency from the `start` sample to `done` is N cycles. Throughput is one operation per N+1 cycles with `start` held high.
- `busy` is high for exactly N cycles per operation.
- CHUNK=WIDTH (N=1) is legal: one RUN cycle. CHUNK=1 is legal: WIDTH RUN cycles.
- No combinational path from any input to any output.

## Test plan
Unless stated, WIDTH=16, CHUNK=4 (N=4).
- **Add, no carry:** add 0x1234+0x4321 → `q`=0x5555, `c_out`=0, `ovf`=0. `busy` high for exactly 4 cycles; `done` a single pulse 4 cycles after capture. `q` holds its old value during RUN.
- **Carry and signed overflow:**
  - 0xFFFF+0x0001 → `q`=0x0000, `c_out`=1, `ovf`=0.
  - 0x7FFF+0x0001 → `q`=0x8000, `c_out`=0, `ovf`=1.
- **Subtract:**
  - `sub`=1, 0x0005−0x0007 → `q`=0xFFFE, `c_out`=0, `ovf`=0.
  - 0x8000−0x0001 → `q`=0x7FFF, `c_out`=1, `ovf`=1.
  - 0x1234−0x1234 → `q`=0x0000, `c_out`=1.
- **Handshake:**
  - Pulse `start` with new operands at RUN edge 2 → ignored; the result belongs to the first operands.
  - Hold `start`=1 continuously → operations accepted every 5 cycles, with `done` and the new `busy` in the same cycle boundary.
- **Reset mid-operation:** assert `rst` asynchronously (off a clock edge) during RUN edge 2 → all outputs read 0 before the next edge. After release, no `done` for 10 cycles; a new 0x0001+0x0001 then yields `q`=0x0002.
- **Parameter sweep:** repeat random add/sub checks against a behavioural `+`/`−` reference for (WIDTH,CHUNK) = (16,16), (16,1) and (32,8). Latency must equal WIDTH/CHUNK in each case.
